// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter sharing one UART TX FIFO write port among NUM_REQ clients.
// Optional idle-grant watchdog enabled by defining UART_ARB_TIMEOUT_EN.

module uart_arb_lane #(
  parameter int DATA_BITS = 8
) (
  input  logic                 grant,
  input  logic                 req,
  input  logic                 last,
  input  logic [DATA_BITS-1:0] data,
  output logic [DATA_BITS-1:0] dataOwn,
  output logic                 reqOwn,
  output logic                 lastOwn
);
  // Grant is one-hot, so OR-ing every lane's masked view yields the owner's view.
  assign dataOwn = grant ? data : '0;
  assign reqOwn  = grant & req;
  assign lastOwn = grant & last;
endmodule

module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_BITS      = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                           Clock,
  input  logic                           Reset,
  input  logic [NUM_REQ-1:0]             Req,
  input  logic [NUM_REQ*DATA_BITS-1:0]   ReqData,
  input  logic [NUM_REQ-1:0]             ReqLast,
  output logic [NUM_REQ-1:0]             ReqAck,
  output logic [NUM_REQ-1:0]             Grant,
  output logic                           Busy,
  output logic                           WriteUart,
  output logic [DATA_BITS-1:0]           WriteData,
  input  logic                           TxFull,
  output logic                           TimeoutPulse
);
  localparam int PW = $clog2(NUM_REQ);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                              state, stateNext;
  logic [PW-1:0]                       ptr, ptrNext, owner, ownerNext, ownerInc, pickIdx;
  logic [NUM_REQ-1:0]                  grantNext, laneReq, laneLast;
  logic [NUM_REQ-1:0][DATA_BITS-1:0]   laneData;
  logic                                busyNext, ownReq, ownLast, xfer, wdHit, pickFound;

  function automatic logic [PW-1:0] rrIdx(input logic [PW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return PW'(s);
  endfunction

  for (genvar i = 0; i < NUM_REQ; i++) begin : gLane
    uart_arb_lane #(.DATA_BITS(DATA_BITS)) uLane (
      .grant  (Grant[i]),
      .req    (Req[i]),
      .last   (ReqLast[i]),
      .data   (ReqData[i*DATA_BITS +: DATA_BITS]),
      .dataOwn(laneData[i]),
      .reqOwn (laneReq[i]),
      .lastOwn(laneLast[i])
    );
  end

  assign ownReq       = |laneReq;
  assign ownLast      = |laneLast;
  assign xfer         = (state == ACTIVE) & ownReq & ~TxFull;
  assign WriteUart    = xfer;
  assign ReqAck       = xfer ? Grant : '0;
  assign TimeoutPulse = wdHit;
  assign ownerInc     = (owner == PW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

  always_comb begin
    WriteData = '0;
    for (int i = 0; i < NUM_REQ; i++) WriteData = WriteData | laneData[i];
  end

  // Scan from the farthest candidate inward so the one nearest ptr wins.
  always_comb begin
    pickFound = 1'b0;
    pickIdx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (Req[rrIdx(ptr, k)]) begin
        pickFound = 1'b1;
        pickIdx   = rrIdx(ptr, k);
      end
    end
  end

  always_comb begin
    stateNext = state;
    grantNext = Grant;
    busyNext  = Busy;
    ptrNext   = ptr;
    ownerNext = owner;
    case (state)
      IDLE: if (pickFound) begin
        stateNext = ACTIVE;
        grantNext = NUM_REQ'(1) << pickIdx;
        busyNext  = 1'b1;
        ownerNext = pickIdx;
      end
      ACTIVE: if ((xfer & ownLast) | wdHit) begin
        stateNext = IDLE;
        grantNext = '0;
        busyNext  = 1'b0;
        ptrNext   = ownerInc;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
      Grant <= '0;
      Busy  <= 1'b0;
      ptr   <= '0;
      owner <= '0;
    end else begin
      state <= stateNext;
      Grant <= grantNext;
      Busy  <= busyNext;
      ptr   <= ptrNext;
      owner <= ownerNext;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wdCnt;

  // Only a silent owner ages the grant; a TxFull stall with data pending never does.
  assign wdHit = (state == ACTIVE) & ~ownReq & (wdCnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge Clock) begin
    if (Reset || state != ACTIVE || xfer || wdHit) wdCnt <= '0;
    else if (!ownReq)                              wdCnt <= wdCnt + 1'b1;
  end
`else
  assign wdHit = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: packet-level reference model checked every cycle, plus directed literal checks.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int DB = 8;
  localparam int TO = 8;
`ifdef UART_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic              Clock = 1'b0;
  logic              Reset = 1'b1;
  logic [N-1:0]      Req = '0, ReqLast = '0;
  logic [N*DB-1:0]   ReqData = '0;
  logic              TxFull = 1'b0;
  logic [N-1:0]      ReqAck, Grant;
  logic              Busy, WriteUart, TimeoutPulse;
  logic [DB-1:0]     WriteData;

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_BITS(DB), .TIMEOUT_CYCLES(TO)) dut (
    .Clock(Clock), .Reset(Reset), .Req(Req), .ReqData(ReqData), .ReqLast(ReqLast),
    .ReqAck(ReqAck), .Grant(Grant), .Busy(Busy), .WriteUart(WriteUart),
    .WriteData(WriteData), .TxFull(TxFull), .TimeoutPulse(TimeoutPulse)
  );

  always #5 Clock = ~Clock;

  typedef struct { int who; logic [7:0] d; logic last; } item_t;
  typedef struct { int who; logic [7:0] d; int cyc; } wr_t;
  item_t srcQ[$];
  wr_t   wlog[$];
  logic [7:0] expD[$];
  int         expW[$];

  int nChecks = 0, nErrors = 0, cyc = 0;
  logic [N-1:0] ackSeen = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int findFirst(input int who);
    for (int j = 0; j < srcQ.size(); j++) if (srcQ[j].who == who) return j;
    return -1;
  endfunction

  task automatic push(input int who, input logic [7:0] d, input logic last);
    item_t it;
    it.who = who; it.d = d; it.last = last;
    srcQ.push_back(it);
  endtask

  // Requester sources: present the head byte of each client, retire it after its ack.
  always @(posedge Clock) begin
    cyc++;
    #1;
    for (int i = 0; i < N; i++) begin
      if (ackSeen[i]) begin
        int j;
        j = findFirst(i);
        if (j >= 0) srcQ.delete(j);
      end
    end
    Req = '0; ReqLast = '0; ReqData = '0;
    for (int i = 0; i < N; i++) begin
      int j;
      j = findFirst(i);
      if (j >= 0) begin
        Req[i] = 1'b1;
        ReqLast[i] = srcQ[j].last;
        ReqData[i*DB +: DB] = srcQ[j].d;
      end
    end
  end

  // Reference model: owner index (-1 = nobody), rr pointer, idle-owner counter.
  int mOwner = -1, mPtr = 0, mCnt = 0;
  bit mValid = 1'b0, xf, eBusy, eWU, eTP, found;
  logic [N-1:0] eGrant, eAck;
  logic [DB-1:0] eWD;

  always @(negedge Clock) begin
    eGrant = '0; eAck = '0; eBusy = 1'b0; eWU = 1'b0; eTP = 1'b0; eWD = '0; xf = 1'b0;
    if (mOwner >= 0) begin
      eGrant[mOwner] = 1'b1;
      eBusy = 1'b1;
      eWD   = ReqData[mOwner*DB +: DB];
      xf    = Req[mOwner] && !TxFull;
      eWU   = xf;
      if (xf) eAck[mOwner] = 1'b1;
      eTP   = TO_EN && !Req[mOwner] && (mCnt == TO - 1);
    end
    if (mValid) begin
      check("Grant", Grant, eGrant);
      check("Busy", Busy, eBusy);
      check("ReqAck", ReqAck, eAck);
      check("WriteUart", WriteUart, eWU);
      check("WriteData", WriteData, eWD);
      check("TimeoutPulse", TimeoutPulse, eTP);
      if (eWU) begin
        wr_t w;
        w.who = mOwner; w.d = eWD; w.cyc = cyc;
        wlog.push_back(w);
      end
    end
    ackSeen = ReqAck;
    if (Reset) begin
      mOwner = -1; mPtr = 0; mCnt = 0; mValid = 1'b1;
    end else if (mValid) begin
      if (mOwner < 0) begin
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
          if (!found && Req[(mPtr + k) % N]) begin
            found = 1'b1; mOwner = (mPtr + k) % N; mCnt = 0;
          end
        end
      end else if ((xf && ReqLast[mOwner]) || eTP) begin
        mPtr = (mOwner + 1) % N; mOwner = -1; mCnt = 0;
      end else if (xf) mCnt = 0;
      else if (!Req[mOwner]) mCnt++;
    end
  end

  task automatic waitDone(input string name);
    int t = 0;
    while ((srcQ.size() != 0 || Busy !== 1'b0) && t < 300) begin
      @(posedge Clock); #2; t++;
    end
    check({name, "_done_in_time"}, t < 300, 1'b1);
  endtask

  task automatic waitLog(input string name, input int n);
    int t = 0;
    while (wlog.size() < n && t < 300) begin
      @(posedge Clock); #2; t++;
    end
    check({name, "_write_in_time"}, t < 300, 1'b1);
  endtask

  task automatic expectLog(input string name, input int gap);
    check({name, "_count"}, wlog.size(), expD.size());
    for (int k = 0; k < expD.size(); k++) begin
      if (k < wlog.size()) begin
        check({name, "_data"}, wlog[k].d, expD[k]);
        check({name, "_who"}, wlog[k].who, expW[k]);
        if (k > 0 && gap > 0) check({name, "_gap"}, wlog[k].cyc - wlog[k-1].cyc, gap);
      end
    end
  endtask

  initial begin
    int fallCyc, t;
    // Reset with every client requesting; then 1-byte packets, client 0 has two.
    push(0, 8'hA0, 1'b1); push(1, 8'hA1, 1'b1); push(2, 8'hA2, 1'b1);
    push(3, 8'hA3, 1'b1); push(0, 8'hB0, 1'b1);
    repeat (3) begin
      @(posedge Clock); #2;
      check("rst_Grant", Grant, 4'b0000);
      check("rst_Busy", Busy, 1'b0);
      check("rst_WriteUart", WriteUart, 1'b0);
    end
    Reset = 1'b0;
    @(posedge Clock); #2;
    check("first_Grant", Grant, 4'b0001);
    check("first_Busy", Busy, 1'b1);
    waitDone("rr");
    expD = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0};
    expW = '{0, 1, 2, 3, 0};
    expectLog("rr", 2);

    // Three-byte packet streams on consecutive cycles.
    wlog.delete();
    push(0, 8'h11, 1'b0); push(0, 8'h22, 1'b0); push(0, 8'h33, 1'b1);
    waitDone("pkt3");
    expD = '{8'h11, 8'h22, 8'h33};
    expW = '{0, 0, 0};
    expectLog("pkt3", 1);
    check("pkt3_Grant", Grant, 4'b0000);
    check("pkt3_Busy", Busy, 1'b0);

    // TxFull stall mid-packet for 5 cycles.
    wlog.delete();
    push(1, 8'h44, 1'b0); push(1, 8'h55, 1'b1);
    waitLog("stall", 1);
    TxFull = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("stall_Grant", Grant, 4'b0010);
      check("stall_WriteUart", WriteUart, 1'b0);
      check("stall_ReqAck", ReqAck, 4'b0000);
      @(posedge Clock); #2;
    end
    TxFull = 1'b0;
    fallCyc = cyc;
    waitDone("stall");
    expD = '{8'h44, 8'h55};
    expW = '{1, 1};
    expectLog("stall", 0);
    if (wlog.size() == 2) check("stall_resume_cycle", wlog[1].cyc, fallCyc);

    // Client 2 arrives while client 0 owns a 4-byte packet.
    wlog.delete();
    push(0, 8'h01, 1'b0); push(0, 8'h02, 1'b0); push(0, 8'h03, 1'b0); push(0, 8'h04, 1'b1);
    t = 0;
    while (Grant !== 4'b0001 && t < 50) begin @(posedge Clock); #2; t++; end
    check("ilv_grant0", Grant, 4'b0001);
    push(2, 8'hC0, 1'b1);
    waitDone("ilv");
    expD = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hC0};
    expW = '{0, 0, 0, 0, 2};
    expectLog("ilv", 0);
    if (wlog.size() == 5) check("ilv_idle_gap", wlog[4].cyc - wlog[3].cyc, 2);

    // Reset mid-packet (stalled so no byte moves in the reset cycle); pointer returns to 0.
    wlog.delete();
    push(1, 8'h61, 1'b0); push(1, 8'h62, 1'b1);
    waitLog("mrst", 1);
    push(0, 8'h70, 1'b1); push(3, 8'h73, 1'b1);
    TxFull = 1'b1; Reset = 1'b1;
    @(posedge Clock); #2;
    check("mrst_Grant", Grant, 4'b0000);
    check("mrst_Busy", Busy, 1'b0);
    Reset = 1'b0; TxFull = 1'b0;
    @(posedge Clock); #2;
    check("mrst_regrant", Grant, 4'b0001);
    waitDone("mrst");
    expD = '{8'h61, 8'h70, 8'h62, 8'h73};
    expW = '{1, 0, 1, 3};
    expectLog("mrst", 0);

`ifdef UART_ARB_TIMEOUT_EN
    // Owner goes silent without Last: watchdog revokes after TO idle cycles.
    wlog.delete();
    push(3, 8'hD3, 1'b0);
    waitLog("wd", 1);
    t = 0;
    while (TimeoutPulse !== 1'b1 && t < 50) begin @(posedge Clock); #2; t++; end
    check("wd_pulse_seen", TimeoutPulse, 1'b1);
    if (wlog.size() >= 1) check("wd_pulse_cycle", cyc - wlog[0].cyc, TO);
    push(0, 8'hE0, 1'b1); push(2, 8'hE2, 1'b1);
    t = 0;
    while (Grant === 4'b0000 && t < 50) begin @(posedge Clock); #2; t++; end
    check("wd_next_grant", Grant, 4'b0001);
    waitDone("wd");
`endif

    repeat (2) @(posedge Clock);
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end
endmodule
